// File: rtl/pc_predict_unit.sv
// Fetch PC register with a direct-mapped branch target buffer and 2-bit direction counters.
// Redirects from EX take priority over predicted advance; a cache stall freezes every piece of state.
module pc_predict_unit #(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int unsigned      BTB_ENTRIES  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_write_en,
    input  logic            is_not_cache_stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_taken,
    input  logic [XLEN-1:0] update_target,
    output logic [XLEN-1:0] current_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic [31:0]     redirect_count
);
    localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
    localparam int unsigned TAGW = XLEN - IDX - 2;

    logic [XLEN-1:0]        current_pc_q, current_pc_d;
    logic [31:0]            redirect_count_q, redirect_count_d;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [1:0]             ctr_q    [BTB_ENTRIES];
    logic [TAGW-1:0]        tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]        target_q [BTB_ENTRIES];

    logic [IDX-1:0]         lk_idx, upd_idx;
    logic [TAGW-1:0]        lk_tag, upd_tag;
    logic                   lk_hit, upd_hit, upd_we, upd_wr_data;
    logic [1:0]             ctr_d;
    logic                   unused_pc_bits;

    assign lk_idx  = current_pc_q[IDX+1:2];
    assign lk_tag  = current_pc_q[XLEN-1:IDX+2];
    assign upd_idx = update_pc[IDX+1:2];
    assign upd_tag = update_pc[XLEN-1:IDX+2];
    assign unused_pc_bits = ^update_pc[1:0];

    // Lookup reads the pre-edge array contents, so a same-cycle update is seen only next cycle.
    assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
    assign pred_target = pred_taken ? target_q[lk_idx] : current_pc_q + XLEN'(4);

    assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_we      = is_not_cache_stall && update_valid && (upd_hit || update_taken);
    assign upd_wr_data = is_not_cache_stall && update_valid && update_taken;

    always_comb begin
        ctr_d = 2'b10;
        if (upd_hit) begin
            if (update_taken)
                ctr_d = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'b01;
            else
                ctr_d = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'b01;
        end
    end

    always_comb begin
        current_pc_d     = current_pc_q;
        redirect_count_d = redirect_count_q;
        if (is_not_cache_stall) begin
            if (redirect_valid) begin
                current_pc_d     = redirect_pc;
                redirect_count_d = redirect_count_q + 32'd1;
            end else if (pc_write_en) begin
                current_pc_d     = pred_target;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            current_pc_q     <= RESET_VECTOR;
            redirect_count_q <= '0;
        end else begin
            current_pc_q     <= current_pc_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < int'(BTB_ENTRIES); i++)
                ctr_q[i] <= 2'b01;
        end else if (upd_we) begin
            valid_q[upd_idx] <= 1'b1;
            ctr_q[upd_idx]   <= ctr_d;
        end
    end

    // Tags and targets need no reset: they are qualified by valid on every read.
    always_ff @(posedge clk) begin
        if (upd_wr_data) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= update_target;
        end
    end

    assign current_pc     = current_pc_q;
    assign redirect_count = redirect_count_q;
endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed and randomized checks of pc_predict_unit against a behavioural fetch/BTB model.
module tb_pc_predict_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_write_en = 1'b0, is_not_cache_stall = 1'b1;
    logic        redirect_valid = 1'b0, update_valid = 1'b0, update_taken = 1'b0;
    logic [31:0] redirect_pc = '0, update_pc = '0, update_target = '0;
    logic [31:0] current_pc, pred_target, redirect_count;
    logic        pred_taken;

    pc_predict_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .BTB_ENTRIES(16)) dut (
        .clk(clk), .reset(reset), .pc_write_en(pc_write_en),
        .is_not_cache_stall(is_not_cache_stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_target(update_target),
        .current_pc(current_pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: each slot remembers the full word address of the branch that owns it.
    bit          m_valid [16];
    logic [31:0] m_owner [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    function automatic int slot(logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[slot(pc)] && (m_owner[slot(pc)] / 4 == pc / 4);
    endfunction

    function automatic bit m_ptaken(logic [31:0] pc);
        return m_hit(pc) && m_ctr[slot(pc)] >= 2;
    endfunction

    function automatic logic [31:0] m_ptarget(logic [31:0] pc);
        logic [31:0] seq;
        seq = pc + 32'd4;
        return m_ptaken(pc) ? m_tgt[slot(pc)] : seq;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_pc  = 32'h0;
        m_cnt = 32'h0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, current_pc, m_pc);
        chk({tag, ".cnt"}, redirect_count, m_cnt);
        chk({tag, ".ptaken"}, {31'b0, pred_taken}, {31'b0, m_ptaken(m_pc)});
        chk({tag, ".ptarget"}, pred_target, m_ptarget(m_pc));
    endtask

    // One clock edge: model state advances from pre-edge values, then outputs are compared.
    task automatic step(input string tag);
        logic [31:0] npc, ncnt;
        int s;
        npc  = m_pc;
        ncnt = m_cnt;
        if (is_not_cache_stall) begin
            if (redirect_valid) begin
                npc  = redirect_pc;
                ncnt = m_cnt + 32'd1;
            end else if (pc_write_en) begin
                npc = m_ptarget(m_pc);
            end
            if (update_valid) begin
                s = slot(update_pc);
                if (m_hit(update_pc)) begin
                    if (update_taken) begin
                        m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                        m_tgt[s] = update_target;
                    end else begin
                        m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
                    end
                end else if (update_taken) begin
                    m_valid[s] = 1'b1;
                    m_owner[s] = update_pc;
                    m_tgt[s]   = update_target;
                    m_ctr[s]   = 2;
                end
            end
        end
        @(posedge clk);
        #1;
        m_pc  = npc;
        m_cnt = ncnt;
        check_all(tag);
        $display("step %-10s pc=%h cnt=%0d ptaken=%0b ptarget=%h", tag, current_pc,
                 redirect_count, pred_taken, pred_target);
    endtask

    task automatic set_in(input bit pwe, input bit nst, input bit rv, input logic [31:0] rpc,
                          input bit uv, input logic [31:0] upc, input bit ut,
                          input logic [31:0] utg);
        pc_write_en = pwe; is_not_cache_stall = nst; redirect_valid = rv; redirect_pc = rpc;
        update_valid = uv; update_pc = upc; update_taken = ut; update_target = utg;
    endtask

    // Reset pulse placed between edges; outputs must settle without a clock.
    task automatic mid_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        chk("rst.pc_const", current_pc, 32'h0);
        chk("rst.ptarget_const", pred_target, 32'h4);
        $display("reset     pc=%h cnt=%0d ptaken=%0b ptarget=%h", current_pc, redirect_count,
                 pred_taken, pred_target);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        mid_reset();

        set_in(1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("seq");
        chk("seq4_pc", current_pc, 32'h10);
        set_in(0, 1, 0, 0, 0, 0, 0, 0);
        step("hold_pwe");
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        step("hold_stall");
        chk("hold_pc", current_pc, 32'h10);

        set_in(0, 1, 0, 0, 1, 32'h10, 1, 32'h40);
        step("alloc10");
        chk("alloc_ptaken", {31'b0, pred_taken}, 32'h1);
        chk("alloc_ptarget", pred_target, 32'h40);
        set_in(1, 1, 0, 0, 0, 0, 0, 0);
        step("jump40");
        chk("jump_pc", current_pc, 32'h40);
        set_in(0, 1, 1, 32'h10, 1, 32'h10, 0, 0);
        step("redir_nt1");
        set_in(0, 1, 0, 0, 1, 32'h10, 0, 0);
        step("nt2");
        chk("nt_ptarget", pred_target, 32'h14);
        set_in(1, 1, 0, 0, 0, 0, 0, 0);
        step("fall14");
        chk("fall_pc", current_pc, 32'h14);

        set_in(0, 1, 1, 32'h100, 0, 0, 0, 0);
        step("redir100");
        chk("redir_pc", current_pc, 32'h100);
        set_in(1, 0, 1, 32'h200, 1, 32'h100, 1, 32'h300);
        step("redir_stall");
        chk("stall_cnt", redirect_count, 32'h2);

        set_in(0, 1, 0, 0, 1, 32'h10, 1, 32'h40);
        step("alloc10b");
        set_in(0, 1, 0, 0, 1, 32'h50, 1, 32'h80);
        step("alias50");
        set_in(0, 1, 1, 32'h10, 0, 0, 0, 0);
        step("to10");
        chk("alias_miss", pred_target, 32'h14);
        set_in(0, 1, 1, 32'h50, 0, 0, 0, 0);
        step("to50");
        chk("alias_hit", pred_target, 32'h80);

        set_in(0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        step("toFFFC");
        set_in(1, 1, 0, 0, 0, 0, 0, 0);
        step("wrap");
        chk("wrap_pc", current_pc, 32'h0);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] hi, upc;
            hi  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 : 32'(($urandom_range(0, 2)) << 6);
            upc = hi | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) upc = current_pc;
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                   $urandom_range(0, 7) == 0,
                   ($urandom_range(0, 1) == 0) ? upc : 32'($urandom) & 32'hFFFF_FFFC,
                   $urandom_range(0, 1) == 1, upc, $urandom_range(0, 2) != 0,
                   32'($urandom) & 32'hFFFF_FFFC);
            if ($urandom_range(0, 99) == 0) mid_reset();
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
